// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern and anode constants
package seg7_pkg;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Active-low anode selects; an[0] = ones, an[1] = tens
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low seven-segment decoder
module bcd_to_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  // Codes 10..15 are not BCD; show a dash so a bad counter is visible
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// rtl/bcd_seg7_scan.sv - two-digit multiplexed common-anode display driver
module bcd_seg7_scan #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] an
);
  import seg7_pkg::*;

  localparam int              CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic          sel;
  logic [3:0]    sh_ones;
  logic [3:0]    sh_tens;

  logic          slot_end;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;

  assign slot_end  = (cnt == CNT_MAX);
  assign cur_digit = sel ? sh_tens : sh_ones;

  bcd_to_seg7 u_dec (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Scan counter and slot select; reset parks at the end of the tens slot
  // so the very first edge is a frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= CNT_MAX;
      sel <= 1'b1;
    end else if (slot_end) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digits are captured only when entering the ones slot, so both halves
  // of a frame always come from the same counter value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_ones <= 4'd0;
      sh_tens <= 4'd0;
    end else if (slot_end && sel) begin
      sh_ones <= digit_1;
      sh_tens <= digit_2;
    end
  end

  // Next output pattern from the current slot; at most one anode is ever low
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (!blank) begin
      if (!sel) begin
        an_nxt  = AN_ONES;
        seg_nxt = cur_seg;
      end else if (!(BLANK_LZ && (sh_tens == 4'd0))) begin
        an_nxt  = AN_TENS;
        seg_nxt = cur_seg;
      end
    end
  end

  // Registered pins; outputs lag sel by one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb/tb_bcd_seg7_scan.sv - directed self-checking bench for bcd_seg7_scan
module tb_bcd_seg7_scan;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] digit_1 = 4'd0;
  logic [3:0] digit_2 = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] seg, seg_nlz;
  logic [1:0] an, an_nlz;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [6:0] P_OFF  = 7'b1111111;
  localparam logic [6:0] P_0    = 7'b1000000;
  localparam logic [6:0] P_2    = 7'b0100100;
  localparam logic [6:0] P_4    = 7'b0011001;
  localparam logic [6:0] P_5    = 7'b0010010;
  localparam logic [6:0] P_6    = 7'b0000010;
  localparam logic [6:0] P_7    = 7'b1111000;
  localparam logic [6:0] P_DASH = 7'b0111111;

  bcd_seg7_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .RST(RST), .digit_1(digit_1), .digit_2(digit_2),
    .blank(blank), .seg(seg), .an(an)
  );

  bcd_seg7_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nlz (
    .CLK(CLK), .RST(RST), .digit_1(digit_1), .digit_2(digit_2),
    .blank(blank), .seg(seg_nlz), .an(an_nlz)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] d2, input logic [3:0] d1);
    RST = 1'b1;
    blank = 1'b0;
    digit_2 = d2;
    digit_1 = d1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] ea;
    logic [6:0] es;
    RST = 1'b1;
    digit_2 = 4'd2;
    digit_1 = 4'd4;
    @(negedge CLK);
    total_cnt++;
    if (an !== 2'b11 || seg !== P_OFF)
      $display("FAIL reset_hold an=%b seg=%b required an=11 seg=%b", an, seg, P_OFF);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 1) begin ea = 2'b11; es = P_OFF; end
      else if (((e - 2) % 8) < 4) begin ea = 2'b10; es = P_4; end
      else begin ea = 2'b01; es = P_2; end
      total_cnt++;
      if (an !== ea || seg !== es)
        $display("FAIL first_frame edge=%0d an=%b seg=%b required an=%b seg=%b", e, an, seg, ea, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_snapshot();
    logic [1:0] ea;
    logic [6:0] es;
    apply_reset(4'd2, 4'd4);
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (e >= 7) begin
        if (((e - 2) % 8) >= 4) begin ea = 2'b01; es = P_2; end
        else begin
          ea = 2'b10;
          es = (e >= 18) ? P_6 : P_5;
        end
        total_cnt++;
        if (an !== ea || seg !== es)
          $display("FAIL snapshot edge=%0d an=%b seg=%b required an=%b seg=%b", e, an, seg, ea, es);
        else pass_cnt++;
      end
      if (e == 6)  digit_1 = 4'd5;
      if (e == 11) digit_1 = 4'd6;
    end
  endtask

  task automatic test_leading_zero();
    logic ones;
    apply_reset(4'd0, 4'd7);
    for (int e = 1; e <= 17; e++) begin
      tick();
      total_cnt++;
      if (an[1] !== 1'b1)
        $display("FAIL lz_tens_anode edge=%0d an=%b required an[1]=1", e, an);
      else pass_cnt++;
      if (e >= 2) begin
        ones = (((e - 2) % 8) < 4);
        total_cnt++;
        if (ones ? (an !== 2'b10 || seg !== P_7) : (an !== 2'b11 || seg !== P_OFF))
          $display("FAIL lz_blank edge=%0d an=%b seg=%b required an=%b seg=%b",
                   e, an, seg, ones ? 2'b10 : 2'b11, ones ? P_7 : P_OFF);
        else pass_cnt++;
        total_cnt++;
        if (ones ? (an_nlz !== 2'b10 || seg_nlz !== P_7) : (an_nlz !== 2'b01 || seg_nlz !== P_0))
          $display("FAIL lz_off edge=%0d an=%b seg=%b required an=%b seg=%b",
                   e, an_nlz, seg_nlz, ones ? 2'b10 : 2'b01, ones ? P_7 : P_0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_invalid();
    logic [1:0] ea;
    apply_reset(4'hF, 4'hC);
    for (int e = 1; e <= 17; e++) begin
      tick();
      total_cnt++;
      if (an === 2'b00 || an_nlz === 2'b00)
        $display("FAIL both_anodes edge=%0d an=%b an_nlz=%b required not 00", e, an, an_nlz);
      else pass_cnt++;
      if (e >= 2) begin
        ea = (((e - 2) % 8) < 4) ? 2'b10 : 2'b01;
        total_cnt++;
        if (an !== ea || seg !== P_DASH)
          $display("FAIL invalid_dash edge=%0d an=%b seg=%b required an=%b seg=%b", e, an, seg, ea, P_DASH);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_blank();
    logic [1:0] ea;
    logic [6:0] es;
    apply_reset(4'd2, 4'd4);
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e >= 2) begin
        if (e >= 3 && e <= 5) begin ea = 2'b11; es = P_OFF; end
        else if (((e - 2) % 8) < 4) begin ea = 2'b10; es = P_4; end
        else begin ea = 2'b01; es = P_2; end
        total_cnt++;
        if (an !== ea || seg !== es)
          $display("FAIL blank edge=%0d an=%b seg=%b required an=%b seg=%b", e, an, seg, ea, es);
        else pass_cnt++;
      end
      if (e == 2) blank = 1'b1;
      if (e == 5) blank = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] ea;
    logic [6:0] es;
    apply_reset(4'd2, 4'd4);
    for (int e = 1; e <= 7; e++) tick();
    total_cnt++;
    if (an !== 2'b01 || seg !== P_2)
      $display("FAIL pre_reset an=%b seg=%b required an=01 seg=%b", an, seg, P_2);
    else pass_cnt++;
    RST = 1'b1;
    #1;
    total_cnt++;
    if (an !== 2'b11 || seg !== P_OFF)
      $display("FAIL async_reset an=%b seg=%b required an=11 seg=%b", an, seg, P_OFF);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 1) begin ea = 2'b11; es = P_OFF; end
      else if (((e - 2) % 8) < 4) begin ea = 2'b10; es = P_4; end
      else begin ea = 2'b01; es = P_2; end
      total_cnt++;
      if (an !== ea || seg !== es)
        $display("FAIL restart edge=%0d an=%b seg=%b required an=%b seg=%b", e, an, seg, ea, es);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_leading_zero();
    test_invalid();
    test_blank();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
